spi_mosi_feeder: RTL and testbench

Upstream stage of spi_master2v0: turns a stream of parallel command/address/data bytes into the serial MOSI_i bit stream and the data_size_i frame length that the master consumes.
- A small byte FIFO decouples the controller from the bit rate.
- Shifting is MSB-first, one bit per cycle while bit_en_i is high.
- The block replaces the hand-driven 8-bit transmit shift register currently used to feed the master.

---
 rtl/spi_mosi_feeder.sv | 180 ++++++++++++++++++
 tb/tb_spi_mosi_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mosi_feeder.sv
// Byte-FIFO fed MSB-first serializer producing MOSI and frame length for spi_master2v0.
// Optional macro SPI_FEEDER_DUMMY_FILL_EN: substitute 8'hFF on FIFO underrun instead of stalling.
module spi_mosi_feeder #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 13
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        wr_valid_i,
   input  logic [7:0]                  wr_data_i,
   output logic                        wr_ready_o,
   input  logic                        start_i,
   input  logic [LEN_W-1:0]            frame_bits_i,
   input  logic                        abort_i,
   input  logic                        bit_en_i,
   output logic                        mosi_o,
   output logic [LEN_W-1:0]            data_size_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        underrun_o,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, STALL, DONE} state_t;

   state_t           state, state_n;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level;
   logic             full, empty, push, pop;
   logic [7:0]       head;

   logic [7:0]       sreg, sreg_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [LEN_W-1:0] remaining, remaining_n;
   logic [LEN_W-1:0] data_size, data_size_n;
   logic             underrun, underrun_n;
   logic             done, done_n;
   logic             need_byte;

   // Ready depends on level only, so a full FIFO refuses a write even on a pop cycle.
   assign full  = (level == LVL_W'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign push  = wr_valid_i && !full;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_idx   <= '0;
         remaining <= '0;
         data_size <= '0;
         underrun  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         sreg      <= sreg_n;
         bit_idx   <= bit_idx_n;
         remaining <= remaining_n;
         data_size <= data_size_n;
         underrun  <= underrun_n;
         done      <= done_n;
      end
   end

   always_comb begin
      state_n     = state;
      sreg_n      = sreg;
      bit_idx_n   = bit_idx;
      remaining_n = remaining;
      data_size_n = data_size;
      underrun_n  = underrun;
      done_n      = 1'b0;
      pop         = 1'b0;
      need_byte   = 1'b0;

      case (state)
         IDLE: begin
            if (start_i) begin
               if (frame_bits_i == '0) begin
                  done_n      = 1'b1;
                  data_size_n = '0;
               end else begin
                  remaining_n = frame_bits_i;
                  data_size_n = frame_bits_i;
                  bit_idx_n   = '0;
                  underrun_n  = 1'b0;
                  need_byte   = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (abort_i) begin
               state_n = IDLE;
            end else if (bit_en_i) begin
               remaining_n = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  // Leftover bits of a partially used byte are simply dropped.
                  state_n = DONE;
                  done_n  = 1'b1;
               end else if (bit_idx == 3'd7) begin
                  bit_idx_n = '0;
                  need_byte = 1'b1;
               end else begin
                  sreg_n    = {sreg[6:0], 1'b0};
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
         end
         STALL: begin
            if (abort_i) begin
               state_n = IDLE;
            end else if (!empty) begin
               pop     = 1'b1;
               sreg_n  = head;
               state_n = SHIFT;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Shared byte-fetch path for frame start and byte-boundary reloads.
      if (need_byte) begin
         if (!empty) begin
            pop     = 1'b1;
            sreg_n  = head;
            state_n = SHIFT;
         end else begin
            underrun_n = 1'b1;
`ifdef SPI_FEEDER_DUMMY_FILL_EN
            sreg_n     = 8'hFF;
            state_n    = SHIFT;
`else
            state_n    = STALL;
`endif
         end
      end
   end

   assign mosi_o       = (state == SHIFT) && sreg[7];
   assign busy_o       = (state == SHIFT) || (state == STALL);
   assign done_o       = done;
   assign underrun_o   = underrun;
   assign data_size_o  = data_size;
   assign fifo_level_o = level;
   assign wr_ready_o   = !full;

endmodule

// File: tb/tb_spi_mosi_feeder.sv
// Self-checking bench for spi_mosi_feeder: directed steps with random data against a
// queue-based model of the byte stream (honours SPI_FEEDER_DUMMY_FILL_EN when defined).
module tb_spi_mosi_feeder;

   localparam int DEPTH = 4;
   localparam int LW    = 13;
   localparam int LVW   = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           wr_valid = 1'b0;
   logic [7:0]     wr_data = '0;
   logic           wr_ready;
   logic           start = 1'b0;
   logic [LW-1:0]  frame_bits = '0;
   logic           abort = 1'b0;
   logic           bit_en = 1'b1;
   logic           mosi;
   logic [LW-1:0]  dsize;
   logic           busy;
   logic           done;
   logic           udr;
   logic [LVW-1:0] level;

   int             checks = 0;
   int             errors = 0;
   byte unsigned   q[$];
   bit             m_udr = 1'b0;
   int             m_ds  = 0;
   logic [7:0]     v8;
   byte unsigned   cb0, cb1;

   spi_mosi_feeder #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
      .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
      .wr_ready_o(wr_ready), .start_i(start), .frame_bits_i(frame_bits),
      .abort_i(abort), .bit_en_i(bit_en), .mosi_o(mosi), .data_size_o(dsize),
      .busy_o(busy), .done_o(done), .underrun_o(udr), .fifo_level_o(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_mosi", mosi, 0);
      chk("rst_data_size", dsize, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_underrun", udr, 0);
      chk("rst_level", level, 0);
   endtask

   task automatic push(input byte unsigned b);
      chk("wr_ready", wr_ready, (q.size() < DEPTH) ? 1 : 0);
      wr_valid = 1'b1;
      wr_data  = b;
      tick();
      wr_valid = 1'b0;
      if (q.size() < DEPTH) q.push_back(b);
      chk("level_after_push", level, q.size());
   endtask

   // Expected stream: queued bytes MSB-first, truncated to nbits; missing bytes read as 8'hFF
   // (only reachable when dummy fill is built in).
   task automatic frame_check(input int nbits, input bit rand_en);
      int           nbytes;
      int           i;
      int           guard;
      bit           en;
      bit           exp[$];
      byte unsigned bb;
      nbytes = (nbits + 7) / 8;
      m_udr  = (nbytes > q.size());
      m_ds   = nbits;
      for (int k = 0; k < nbytes; k++) begin
         bb = (q.size() > 0) ? q.pop_front() : 8'hFF;
         for (int j = 7; j >= 0; j--) exp.push_back(bb[j]);
      end
      start      = 1'b1;
      frame_bits = LW'(nbits);
      tick();
      start = 1'b0;
      i     = 0;
      guard = 0;
      while (i < nbits && guard < 4000) begin
         chk("mosi_bit", mosi, exp[i]);
         chk("busy_frame", busy, 1);
         chk("done_mid", done, 0);
         en     = rand_en ? bit'($urandom_range(0, 1)) : 1'b1;
         bit_en = en;
         tick();
         if (en) i++;
         guard++;
      end
      bit_en = 1'b1;
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("mosi_done", mosi, 0);
      chk("data_size", dsize, m_ds);
      chk("underrun_frame", udr, m_udr);
      chk("level_end", level, q.size());
      tick();
      chk("done_clear", done, 0);
   endtask

   initial begin
      int n;
      int nb;
      byte unsigned x2;

      #2 rst = 1'b0;
      #10;
      chk_reset_vals();
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      chk_reset_vals();

      // Command/address stream, then a dropped write into a full FIFO.
      push(8'h0B); push(8'hBB); push(8'hBB); push(8'hBB);
      chk("full_ready", wr_ready, 0);
      push(8'h5A);
      frame_check(32, 1'b0);

      // Zero-length frame.
      start      = 1'b1;
      frame_bits = '0;
      tick();
      start = 1'b0;
      chk("zlen_done", done, 1);
      chk("zlen_busy", busy, 0);
      chk("zlen_data_size", dsize, 0);
      tick();
      chk("zlen_done_clear", done, 0);

      // Partial last byte.
      push(8'hF0); push(8'h3C);
      frame_check(12, 1'b0);

`ifdef SPI_FEEDER_DUMMY_FILL_EN
      frame_check(8, 1'b0);
      push(8'h0B);
      frame_check(16, 1'b0);
      chk("udr_sticky", udr, 1);
`else
      // Underrun: one byte queued for a 16-bit frame, second byte arrives late.
      push(8'h0B);
      start      = 1'b1;
      frame_bits = LW'(16);
      tick();
      start = 1'b0;
      void'(q.pop_front());
      v8 = 8'h0B;
      for (int i = 0; i < 8; i++) begin
         chk("stall_pre_mosi", mosi, v8[7-i]);
         tick();
      end
      chk("stall_underrun", udr, 1);
      for (int k = 0; k < 9; k++) begin
         chk("stall_mosi", mosi, 0);
         chk("stall_busy", busy, 1);
         chk("stall_done", done, 0);
         tick();
      end
      wr_valid = 1'b1;
      wr_data  = 8'hA5;
      tick();
      wr_valid = 1'b0;
      chk("stall_push_mosi", mosi, 0);
      chk("stall_push_level", level, 1);
      tick();
      v8 = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk("stall_post_mosi", mosi, v8[7-i]);
         chk("stall_post_busy", busy, 1);
         tick();
      end
      chk("stall_done_pulse", done, 1);
      chk("stall_level", level, 0);
      chk("stall_data_size", dsize, 16);
      tick();
      chk("udr_sticky", udr, 1);
      m_udr = 1'b1;
`endif

      // Full-FIFO write on a pop cycle is refused; a non-full push+pop keeps the level.
      for (int k = 0; k < DEPTH; k++) push(byte'($urandom));
      cb0 = q.pop_front();
      cb1 = q.pop_front();
      x2  = byte'($urandom);
      start      = 1'b1;
      frame_bits = LW'(16);
      wr_valid   = 1'b1;
      wr_data    = byte'($urandom);
      tick();
      start    = 1'b0;
      wr_valid = 1'b0;
      chk("popfull_level", level, 3);
      chk("popfull_ready", wr_ready, 1);
      for (int i = 0; i < 16; i++) begin
         v8 = (i < 8) ? cb0 : cb1;
         chk("pp_mosi", mosi, v8[7-(i%8)]);
         if (i == 7) begin
            wr_valid = 1'b1;
            wr_data  = x2;
         end
         tick();
         wr_valid = 1'b0;
         if (i == 7) chk("pushpop_level", level, 3);
      end
      q.push_back(x2);
      chk("pp_done", done, 1);
      chk("pp_underrun", udr, 0);
      tick();
      frame_check(24, 1'b0);

      // Abort after 5 bits; a start pulse while busy is ignored.
      for (int k = 0; k < DEPTH; k++) push(byte'($urandom));
      v8 = q.pop_front();
      start      = 1'b1;
      frame_bits = LW'(32);
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("abort_mosi", mosi, v8[7-i]);
         if (i == 2) begin
            start      = 1'b1;
            frame_bits = LW'(5);
         end
         tick();
         start = 1'b0;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_mosi_idle", mosi, 0);
      chk("abort_done", done, 0);
      chk("abort_level", level, 3);
      chk("abort_data_size", dsize, 32);
      tick();
      chk("abort_done_late", done, 0);
      frame_check(24, 1'b0);

      // Random data, lengths and bit_en gaps.
      for (int r = 0; r < 8; r++) begin
         n = $urandom_range(1, DEPTH - q.size());
         for (int k = 0; k < n; k++) push(byte'($urandom));
         nb = $urandom_range(1, 8 * q.size());
         frame_check(nb, 1'b1);
      end

      // Asynchronous reset mid-frame.
      while (q.size() < 2) push(byte'($urandom));
      start      = 1'b1;
      frame_bits = LW'(16);
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b0;
      #1;
      chk_reset_vals();
      q.delete();
      m_udr = 1'b0;
      m_ds  = 0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      push(byte'($urandom));
      frame_check(8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
